distortion_core: RTL and testbench

DISTORTION_CORE -- requirements
Module: distortion_core

---
 rtl/distortion_pkg.sv | 30 +++
 rtl/clip_indicator.sv | 64 ++++++
 rtl/distortion_core.sv | 123 ++++++++++++
 tb/tb_distortion_core.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/distortion_pkg.sv
// Shared types, limits and input-conditioning helpers for the distortion pipeline.
package distortion_pkg;

    typedef logic signed [15:0] sample_t;
    typedef logic signed [31:0] product_t;

    typedef enum logic {
        IDLE,
        HOLD
    } clip_state_t;

    localparam sample_t  GAIN_MIN = 16'sd1;
    localparam sample_t  GAIN_MAX = 16'sd50;
    localparam product_t THR_MIN  = 32'sd1;
    localparam product_t THR_MAX  = 32'sd32767;

    function automatic sample_t clamp_gain(input sample_t g);
        if (g < GAIN_MIN) return GAIN_MIN;
        if (g > GAIN_MAX) return GAIN_MAX;
        return g;
    endfunction

    // The clamped threshold always fits a positive 16-bit sample.
    function automatic sample_t clamp_thr(input product_t t);
        if (t < THR_MIN) return sample_t'(THR_MIN);
        if (t > THR_MAX) return sample_t'(THR_MAX);
        return sample_t'(t);
    endfunction

endpackage

// File: rtl/clip_indicator.sv
// Stretches single clip events into a visible LED pulse lasting CLIP_HOLD
// unclipped output samples after the most recent clip.
module clip_indicator
    import distortion_pkg::*;
#(
    parameter int unsigned CLIP_HOLD = 4800
) (
    input  logic CLK,
    input  logic RST,
    input  logic i_valid,
    input  logic i_clip,
    output logic o_led
);

    localparam int unsigned CNT_W = $clog2(CLIP_HOLD + 2);

    clip_state_t       r_state;
    clip_state_t       w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // The counter reaches 0 on the CLIP_HOLD-th unclipped sample, which still
    // shows the LED; the following unclipped sample drops back to IDLE.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (i_valid && i_clip) begin
                    w_state_nxt = HOLD;
                    w_cnt_nxt   = CNT_W'(CLIP_HOLD);
                end
            end
            HOLD: begin
                if (i_valid) begin
                    if (i_clip) begin
                        w_cnt_nxt = CNT_W'(CLIP_HOLD);
                    end else if (r_cnt == '0) begin
                        w_state_nxt = IDLE;
                    end else begin
                        w_cnt_nxt = r_cnt - 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign o_led = (r_state == HOLD);

endmodule

// File: rtl/distortion_core.sv
// Three-stage hard-clipping distortion: capture/clamp, multiply, clip.
// Fixed 3-cycle latency, no backpressure, with a stretched clip LED.
module distortion_core
    import distortion_pkg::*;
#(
    parameter int unsigned CLIP_HOLD = 4800
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic signed [15:0]  sample_in,
    input  logic                sample_in_valid,
    input  logic signed [15:0]  gain,
    input  logic signed [31:0]  threshold,
    input  logic                disabled,
    output logic signed [15:0]  sample_out,
    output logic                sample_out_valid,
    output logic                clip_active,
    output logic                clip_led
);

    logic     r_s1_valid;
    sample_t  r_s1_sample;
    sample_t  r_s1_gain;
    sample_t  r_s1_thr;
    logic     r_s1_dis;

    logic     r_s2_valid;
    product_t r_s2_prod;
    sample_t  r_s2_sample;
    sample_t  r_s2_thr;
    logic     r_s2_dis;

    sample_t  r_sample_out;
    logic     r_out_valid;
    logic     r_clip_active;

    product_t w_thr_ext;
    logic     w_clip_hi;
    logic     w_clip_lo;
    logic     w_clip;
    sample_t  w_result;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_s1_valid  <= 1'b0;
            r_s1_sample <= '0;
            r_s1_gain   <= '0;
            r_s1_thr    <= '0;
            r_s1_dis    <= 1'b0;
        end else begin
            r_s1_valid <= sample_in_valid;
            if (sample_in_valid) begin
                r_s1_sample <= sample_in;
                r_s1_gain   <= clamp_gain(gain);
                r_s1_thr    <= clamp_thr(threshold);
                r_s1_dis    <= disabled;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_s2_valid  <= 1'b0;
            r_s2_prod   <= '0;
            r_s2_sample <= '0;
            r_s2_thr    <= '0;
            r_s2_dis    <= 1'b0;
        end else begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_prod   <= product_t'(r_s1_sample) * product_t'(r_s1_gain);
                r_s2_sample <= r_s1_sample;
                r_s2_thr    <= r_s1_thr;
                r_s2_dis    <= r_s1_dis;
            end
        end
    end

    assign w_thr_ext = product_t'(r_s2_thr);
    assign w_clip_hi = (r_s2_prod > w_thr_ext);
    assign w_clip_lo = (r_s2_prod < -w_thr_ext);
    assign w_clip    = !r_s2_dis && (w_clip_hi || w_clip_lo);

    always_comb begin
        w_result = r_s2_prod[15:0];
        if (r_s2_dis) begin
            w_result = r_s2_sample;
        end else if (w_clip_hi) begin
            w_result = r_s2_thr;
        end else if (w_clip_lo) begin
            w_result = -r_s2_thr;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_sample_out  <= '0;
            r_out_valid   <= 1'b0;
            r_clip_active <= 1'b0;
        end else begin
            r_out_valid   <= r_s2_valid;
            r_clip_active <= r_s2_valid && w_clip;
            if (r_s2_valid) begin
                r_sample_out <= w_result;
            end
        end
    end

    clip_indicator #(
        .CLIP_HOLD (CLIP_HOLD)
    ) u_clip_indicator (
        .CLK     (CLK),
        .RST     (RST),
        .i_valid (r_s2_valid),
        .i_clip  (w_clip),
        .o_led   (clip_led)
    );

    assign sample_out       = r_sample_out;
    assign sample_out_valid = r_out_valid;
    assign clip_active      = r_clip_active;

endmodule

// File: tb/tb_distortion_core.sv
// Randomized and directed bench for distortion_core against an arithmetic
// reference model with a queue of expected outputs.
module tb_distortion_core;

    localparam int unsigned HOLD = 4;

    logic               CLK = 1'b0;
    logic               RST = 1'b1;
    logic signed [15:0] sample_in = '0;
    logic               sample_in_valid = 1'b0;
    logic signed [15:0] gain = '0;
    logic signed [31:0] threshold = '0;
    logic               disabled = 1'b0;
    logic signed [15:0] sample_out;
    logic               sample_out_valid;
    logic               clip_active;
    logic               clip_led;

    distortion_core #(
        .CLIP_HOLD (HOLD)
    ) dut (
        .CLK              (CLK),
        .RST              (RST),
        .sample_in        (sample_in),
        .sample_in_valid  (sample_in_valid),
        .gain             (gain),
        .threshold        (threshold),
        .disabled         (disabled),
        .sample_out       (sample_out),
        .sample_out_valid (sample_out_valid),
        .clip_active      (clip_active),
        .clip_led         (clip_led)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int due;
        int val;
        bit clip;
    } exp_t;

    exp_t q[$];
    int   n_vec    = 0;
    int   n_err    = 0;
    int   edge_n   = 0;
    int   last_out = 0;
    bit   led_seen = 1'b0;
    int   since    = 0;

    task automatic check(input string tag, input longint got, input longint exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, edge_n);
        end
    endtask

    function automatic void model(input int s, input int g, input int t, input bit dis,
                                  output int y, output bit c);
        longint p;
        if (dis) begin
            y = s;
            c = 1'b0;
            return;
        end
        if (g < 1)     g = 1;
        if (g > 50)    g = 50;
        if (t < 1)     t = 1;
        if (t > 32767) t = 32767;
        p = longint'(s) * longint'(g);
        if (p > t) begin
            y = t;
            c = 1'b1;
        end else if (p < -t) begin
            y = -t;
            c = 1'b1;
        end else begin
            y = int'(p);
            c = 1'b0;
        end
    endfunction

    task automatic step();
        int   y;
        bit   c;
        exp_t e;
        if (sample_in_valid && !RST) begin
            model(int'(sample_in), int'(gain), int'(threshold), disabled, y, c);
            q.push_back('{edge_n + 2, y, c});
        end
        @(posedge CLK);
        #1;
        if (q.size() > 0 && q[0].due == edge_n) begin
            e = q.pop_front();
            check("out_valid", sample_out_valid, 1);
            check("sample_out", sample_out, e.val);
            check("clip_active", clip_active, e.clip);
            last_out = e.val;
            if (e.clip) begin
                led_seen = 1'b1;
                since    = 0;
            end else if (led_seen) begin
                since++;
                if (since > int'(HOLD)) led_seen = 1'b0;
            end
        end else begin
            check("idle_valid", sample_out_valid, 0);
            check("idle_clip", clip_active, 0);
            check("hold_out", sample_out, last_out);
        end
        check("clip_led", clip_led, led_seen);
        edge_n++;
    endtask

    task automatic send(input int s, input int g, input int t, input bit d);
        sample_in       = 16'(s);
        gain            = 16'(g);
        threshold       = 32'(t);
        disabled        = d;
        sample_in_valid = 1'b1;
        step();
        sample_in_valid = 1'b0;
    endtask

    // Scrambles the parameter inputs while idle so captured values are exercised.
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            sample_in       = 16'($urandom);
            gain            = 16'($urandom);
            threshold       = 32'($urandom);
            disabled        = 1'($urandom);
            sample_in_valid = 1'b0;
            step();
        end
    endtask

    initial begin
        step();
        step();
        check("rst_out", sample_out, 0);
        check("rst_led", clip_led, 0);
        RST = 1'b0;

        send(1234, 10, 5000, 1'b1);
        idle(3);

        send(300, 10, 5000, 1'b0);
        send(600, 10, 5000, 1'b0);
        send(-600, 10, 5000, 1'b0);
        idle(3);

        send(-32768, 80, 40000, 1'b0);
        idle(3);

        send(100, 2, 5000, 1'b0);
        send(100, 5, 5000, 1'b0);
        idle(3);

        send(500, 10, 5000, 1'b0);
        send(-500, 10, 5000, 1'b0);
        send(7, 0, -5, 1'b0);
        send(-7, -3, 0, 1'b0);
        send(32767, 50, 32767, 1'b0);
        idle(3);

        idle(8);
        send(600, 10, 5000, 1'b0);
        for (int i = 0; i < 5; i++) send(10 + i, 1, 5000, 1'b0);
        idle(4);

        send(1000, 3, 100, 1'b0);
        #2;
        RST = 1'b1;
        q.delete();
        last_out = 0;
        led_seen = 1'b0;
        since    = 0;
        #1;
        check("async_rst_valid", sample_out_valid, 0);
        check("async_rst_out", sample_out, 0);
        check("async_rst_led", clip_led, 0);
        step();
        step();
        RST = 1'b0;
        idle(4);
        send(-20, 4, 1000, 1'b0);
        idle(3);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) < 7) begin
                send(int'($urandom),
                     int'($urandom_range(0, 70)) - 10,
                     ($urandom_range(0, 1) == 1) ? int'($urandom)
                                                 : int'($urandom_range(0, 40000)) - 100,
                     ($urandom_range(0, 9) == 0));
            end else begin
                idle(1);
            end
        end
        idle(4);
        check("queue_drained", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
